// File: rtl/aes_keyram_dbuf.sv
// Double-buffered AES round-key store: 64-bit words fill a shadow bank while the
// engine reads the active bank; banks swap only when the engine is idle.
module aes_keyram_dbuf #(
  parameter int WORD_W = 64,
  parameter int NK_MAX = 15,
  parameter int AW     = 4
) (
  input  logic                  clk,
  input  logic                  kill,
  input  logic [1:0]            key_len,
  input  logic                  en_wr,
  input  logic [WORD_W-1:0]     key_round_wr,
  input  logic                  busy,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [2*WORD_W-1:0]   rd_key,
  output logic [3:0]            active_nr,
  output logic                  key_valid,
  output logic                  swap_pending,
  output logic                  load_done_pulse,
  output logic                  wr_err_irq_pulse
);

  localparam int CW = $clog2(2*NK_MAX+1);

  logic [CW-1:0]         wordCnt_q, wordCnt_d;
  logic [1:0]            keyLen_q, keyLen_d;
  logic                  pend_q, pend_d;
  logic                  bankSel_q, bankSel_d;
  logic                  valid_q, valid_d;
  logic [3:0]            activeNr_q, activeNr_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [2*WORD_W-1:0]   rdKey_q, rdKey_d;
  logic                  wrEn;
  logic [1:0]            effLen;
  logic                  rdOk;

  logic [2*WORD_W-1:0]   mem [2][NK_MAX];

  function automatic logic [CW-1:0] wordsFor(input logic [1:0] len);
    case (len)
      2'd0:    wordsFor = CW'(22);
      2'd1:    wordsFor = CW'(26);
      default: wordsFor = CW'(30);
    endcase
  endfunction

  function automatic logic [3:0] roundsFor(input logic [1:0] len);
    case (len)
      2'd0:    roundsFor = 4'd10;
      2'd1:    roundsFor = 4'd12;
      default: roundsFor = 4'd14;
    endcase
  endfunction

  // key_len is only honoured on the first word of a load; later words use the latched copy
  always_comb begin
    wordCnt_d  = wordCnt_q;
    keyLen_d   = keyLen_q;
    pend_d     = pend_q;
    bankSel_d  = bankSel_q;
    valid_d    = valid_q;
    activeNr_d = activeNr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wrEn       = 1'b0;
    effLen     = (wordCnt_q == '0) ? key_len : keyLen_q;

    if (pend_q) begin
      if (en_wr) err_d = 1'b1;
      if (!busy) begin
        bankSel_d  = ~bankSel_q;
        valid_d    = 1'b1;
        activeNr_d = roundsFor(keyLen_q);
        pend_d     = 1'b0;
        wordCnt_d  = '0;
        done_d     = 1'b1;
      end
    end else if (en_wr) begin
      if (wordCnt_q == '0 && key_len == 2'd3) begin
        err_d = 1'b1;
      end else begin
        wrEn      = 1'b1;
        keyLen_d  = effLen;
        wordCnt_d = wordCnt_q + CW'(1);
        if (wordCnt_q == wordsFor(effLen) - CW'(1)) pend_d = 1'b1;
      end
    end

    // Reads see pre-edge bank select, so a read on the swap edge returns the old bank
    rdOk    = valid_q && (32'(rd_addr) <= 32'(activeNr_q)) && (32'(rd_addr) < NK_MAX);
    rdKey_d = rdKey_q;
    if (rd_en) rdKey_d = rdOk ? mem[bankSel_q][rd_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      wordCnt_q  <= '0;
      keyLen_q   <= '0;
      pend_q     <= 1'b0;
      bankSel_q  <= 1'b0;
      valid_q    <= 1'b0;
      activeNr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdKey_q    <= '0;
    end else begin
      wordCnt_q  <= wordCnt_d;
      keyLen_q   <= keyLen_d;
      pend_q     <= pend_d;
      bankSel_q  <= bankSel_d;
      valid_q    <= valid_d;
      activeNr_q <= activeNr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdKey_q    <= rdKey_d;
    end
  end

  // Storage is never cleared; even words fill the low half of a round key, odd words the high half
  always_ff @(posedge clk) begin
    if (!kill && wrEn) begin
      if (wordCnt_q[0])
        mem[~bankSel_q][wordCnt_q[CW-1:1]][2*WORD_W-1:WORD_W] <= key_round_wr;
      else
        mem[~bankSel_q][wordCnt_q[CW-1:1]][WORD_W-1:0] <= key_round_wr;
    end
  end

  assign rd_key           = rdKey_q;
  assign active_nr        = activeNr_q;
  assign key_valid        = valid_q;
  assign swap_pending     = pend_q;
  assign load_done_pulse  = done_q;
  assign wr_err_irq_pulse = err_q;

endmodule

// File: tb/tb_aes_keyram_dbuf.sv
// Directed bench for aes_keyram_dbuf: loads, busy-held swaps, rejected writes,
// AES-256 schedules and reset during a load.
module tb_aes_keyram_dbuf;

  logic          clk = 1'b0;
  logic          kill;
  logic [1:0]    key_len;
  logic          en_wr;
  logic [63:0]   key_round_wr;
  logic          busy;
  logic          rd_en;
  logic [3:0]    rd_addr;
  logic [127:0]  rd_key;
  logic [3:0]    active_nr;
  logic          key_valid;
  logic          swap_pending;
  logic          load_done_pulse;
  logic          wr_err_irq_pulse;

  int nChecks = 0;
  int nPassed = 0;

  aes_keyram_dbuf dut (
    .clk              (clk),
    .kill             (kill),
    .key_len          (key_len),
    .en_wr            (en_wr),
    .key_round_wr     (key_round_wr),
    .busy             (busy),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_key           (rd_key),
    .active_nr        (active_nr),
    .key_valid        (key_valid),
    .swap_pending     (swap_pending),
    .load_done_pulse  (load_done_pulse),
    .wr_err_irq_pulse (wr_err_irq_pulse)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are observed 1ns after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_key(input logic [3:0] addr);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    kill = 1'b1; key_len = 2'd0; en_wr = 1'b0; key_round_wr = '0;
    busy = 1'b0; rd_en = 1'b0; rd_addr = '0;
    tick(); tick();
    kill = 1'b0;
    nChecks++;
    if ({rd_key, active_nr, key_valid, swap_pending, load_done_pulse, wr_err_irq_pulse} !== '0)
      $display("[TB] FAIL reset_outputs: got key=%h nr=%0d v=%b p=%b d=%b e=%b want all zero",
               rd_key, active_nr, key_valid, swap_pending, load_done_pulse, wr_err_irq_pulse);
    else nPassed++;
    read_key(4'd0);
    nChecks++;
    if (rd_key !== 128'h0) $display("[TB] FAIL reset_read: got %h want 0", rd_key);
    else nPassed++;
  endtask

  task automatic test_basic_load();
    key_len = 2'd0;
    for (int i = 0; i < 22; i++) begin
      en_wr = 1'b1; key_round_wr = 64'(i);
      tick();
    end
    en_wr = 1'b0;
    nChecks++;
    if (swap_pending !== 1'b1 || load_done_pulse !== 1'b0)
      $display("[TB] FAIL basic_pending: got p=%b d=%b want p=1 d=0", swap_pending, load_done_pulse);
    else nPassed++;
    tick();
    nChecks++;
    if (load_done_pulse !== 1'b1 || active_nr !== 4'd10 || key_valid !== 1'b1 || swap_pending !== 1'b0)
      $display("[TB] FAIL basic_swap: got d=%b nr=%0d v=%b p=%b want d=1 nr=10 v=1 p=0",
               load_done_pulse, active_nr, key_valid, swap_pending);
    else nPassed++;
    tick();
    nChecks++;
    if (load_done_pulse !== 1'b0) $display("[TB] FAIL basic_pulse_width: got %b want 0", load_done_pulse);
    else nPassed++;
    read_key(4'd3);
    nChecks++;
    if (rd_key !== 128'h7_0000000000000006)
      $display("[TB] FAIL basic_read3: got %h want %h", rd_key, 128'h7_0000000000000006);
    else nPassed++;
    rd_addr = 4'd5;
    tick();
    nChecks++;
    if (rd_key !== 128'h7_0000000000000006)
      $display("[TB] FAIL basic_read_hold: got %h want %h", rd_key, 128'h7_0000000000000006);
    else nPassed++;
    read_key(4'd11);
    nChecks++;
    if (rd_key !== 128'h0) $display("[TB] FAIL basic_read11: got %h want 0", rd_key);
    else nPassed++;
  endtask

  task automatic test_busy_hold();
    int bad;
    busy = 1'b1; key_len = 2'd0;
    for (int i = 0; i < 22; i++) begin
      en_wr = 1'b1; key_round_wr = 64'h100 + 64'(i);
      tick();
    end
    key_round_wr = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    en_wr = 1'b0;
    nChecks++;
    if (wr_err_irq_pulse !== 1'b1 || swap_pending !== 1'b1)
      $display("[TB] FAIL overflow_err: got e=%b p=%b want e=1 p=1", wr_err_irq_pulse, swap_pending);
    else nPassed++;
    tick();
    nChecks++;
    if (wr_err_irq_pulse !== 1'b0) $display("[TB] FAIL overflow_err_width: got %b want 0", wr_err_irq_pulse);
    else nPassed++;
    bad = 0;
    rd_en = 1'b1; rd_addr = 4'd3;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_key !== 128'h7_0000000000000006 || swap_pending !== 1'b1 || load_done_pulse !== 1'b0) bad++;
    end
    nChecks++;
    if (bad != 0) $display("[TB] FAIL busy_hold: got %0d bad cycles want 0", bad);
    else nPassed++;
    busy = 1'b0; rd_addr = 4'd0;
    tick();
    nChecks++;
    if (load_done_pulse !== 1'b1 || rd_key !== 128'h1_0000000000000000)
      $display("[TB] FAIL swap_edge_read: got d=%b key=%h want d=1 key=%h",
               load_done_pulse, rd_key, 128'h1_0000000000000000);
    else nPassed++;
    tick();
    rd_en = 1'b0;
    nChecks++;
    if (rd_key !== {64'h101, 64'h100} || load_done_pulse !== 1'b0)
      $display("[TB] FAIL after_swap_read: got d=%b key=%h want d=0 key=%h",
               load_done_pulse, rd_key, {64'h101, 64'h100});
    else nPassed++;
    read_key(4'd10);
    nChecks++;
    if (rd_key !== {64'h115, 64'h114} || active_nr !== 4'd10)
      $display("[TB] FAIL overflow_contents: got key=%h nr=%0d want key=%h nr=10",
               rd_key, active_nr, {64'h115, 64'h114});
    else nPassed++;
  endtask

  task automatic test_aes256();
    en_wr = 1'b1; key_len = 2'd3; key_round_wr = 64'hBAD;
    tick();
    nChecks++;
    if (wr_err_irq_pulse !== 1'b1) $display("[TB] FAIL reserved_err: got %b want 1", wr_err_irq_pulse);
    else nPassed++;
    for (int i = 0; i < 30; i++) begin
      key_len = (i == 0) ? 2'd2 : 2'd0;
      key_round_wr = 64'h200 + 64'(i);
      tick();
      if (i == 28) begin
        nChecks++;
        if (swap_pending !== 1'b0 || wr_err_irq_pulse !== 1'b0)
          $display("[TB] FAIL aes256_early: got p=%b e=%b want p=0 e=0", swap_pending, wr_err_irq_pulse);
        else nPassed++;
      end
    end
    en_wr = 1'b0;
    nChecks++;
    if (swap_pending !== 1'b1) $display("[TB] FAIL aes256_pending: got %b want 1", swap_pending);
    else nPassed++;
    tick();
    nChecks++;
    if (load_done_pulse !== 1'b1 || active_nr !== 4'd14)
      $display("[TB] FAIL aes256_swap: got d=%b nr=%0d want d=1 nr=14", load_done_pulse, active_nr);
    else nPassed++;
    read_key(4'd14);
    nChecks++;
    if (rd_key !== {64'h21d, 64'h21c})
      $display("[TB] FAIL aes256_read14: got %h want %h", rd_key, {64'h21d, 64'h21c});
    else nPassed++;
    read_key(4'd15);
    nChecks++;
    if (rd_key !== 128'h0) $display("[TB] FAIL aes256_read15: got %h want 0", rd_key);
    else nPassed++;
  endtask

  task automatic test_reset_midload();
    key_len = 2'd0;
    for (int i = 0; i < 10; i++) begin
      en_wr = 1'b1; key_round_wr = 64'h300 + 64'(i);
      tick();
    end
    en_wr = 1'b0; kill = 1'b1;
    tick();
    kill = 1'b0;
    nChecks++;
    if ({rd_key, active_nr, key_valid, swap_pending, load_done_pulse, wr_err_irq_pulse} !== '0)
      $display("[TB] FAIL midload_reset: got key=%h nr=%0d v=%b p=%b d=%b e=%b want all zero",
               rd_key, active_nr, key_valid, swap_pending, load_done_pulse, wr_err_irq_pulse);
    else nPassed++;
    for (int i = 0; i < 22; i++) begin
      en_wr = 1'b1; key_round_wr = 64'h400 + 64'(i);
      tick();
    end
    en_wr = 1'b0;
    nChecks++;
    if (swap_pending !== 1'b1) $display("[TB] FAIL fresh_pending: got %b want 1", swap_pending);
    else nPassed++;
    tick();
    nChecks++;
    if (load_done_pulse !== 1'b1 || key_valid !== 1'b1 || active_nr !== 4'd10)
      $display("[TB] FAIL fresh_swap: got d=%b v=%b nr=%0d want d=1 v=1 nr=10",
               load_done_pulse, key_valid, active_nr);
    else nPassed++;
    read_key(4'd10);
    nChecks++;
    if (rd_key !== {64'h415, 64'h414})
      $display("[TB] FAIL fresh_read10: got %h want %h", rd_key, {64'h415, 64'h414});
    else nPassed++;
    read_key(4'd0);
    nChecks++;
    if (rd_key !== {64'h401, 64'h400})
      $display("[TB] FAIL fresh_read0: got %h want %h", rd_key, {64'h401, 64'h400});
    else nPassed++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_busy_hold();
    test_aes256();
    test_reset_midload();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/aes_keyram_dbuf.md
Name: aes_keyram_dbuf

Overview:
- Double-buffered round-key RAM for the AES core.
- Generalises the single 128-bit key store to AES-128/192/256 schedules, selected per load.
- Round keys stream in as 64-bit words into a shadow bank while the engine keeps reading the active bank. The shadow bank is swapped in atomically only when the engine is idle.
- Sits between the key-write interface and the round pipeline's key fetch.

Parameters:
WORD_W, 64, key-write word width; WORD_W*2 = round-key width (128)
NK_MAX, 15, max round keys per bank (AES-256: 14 rounds + 1)
AW, 4, rd_addr width; must satisfy 2**AW >= NK_MAX

Ports:
clk  in  1  clock
kill  in  1  synchronous active-high reset
key_len  in  2  key size for the load; sampled at the first word only. 0=128 (11 keys), 1=192 (13), 2=256 (15), 3=reserved
en_wr  in  1  key word valid
key_round_wr  in  WORD_W  key word
busy  in  1  engine has a block in flight; swap is blocked while high
rd_en  in  1  round-key read strobe
rd_addr  in  AW  round index 0..NR
rd_key  out  2*WORD_W  round key, registered
active_nr  out  4  round count of the active bank (10/12/14; 0 when invalid)
key_valid  out  1  active bank holds a complete schedule
swap_pending  out  1  shadow complete, waiting for busy=0
load_done_pulse  out  1  one-cycle pulse on swap
wr_err_irq_pulse  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset (kill=1 at a clk edge; wins over all other inputs):
  - All outputs are 0.
  - Word counter is 0; bank select is 0; both banks are marked invalid.
  - RAM contents are not cleared.
  - Reset mid-load discards the partial load.
- Load phase:
  - In the idle state (counter=0, pending=0), an edge with en_wr=1 and key_len!=3 latches key_len, writes the word, and sets counter=1.
  - Word 2k goes to shadow key k bits [WORD_W-1:0]. Word 2k+1 goes to bits [2*WORD_W-1:WORD_W].
  - Required word counts: 22 / 26 / 30.
  - Gaps in en_wr are allowed; the load persists indefinitely.
  - key_len changes after the first word are ignored for that load.
- Completion: at the edge that captures the last required word, swap_pending<=1 and the counter is held.
- Swap: at any edge with swap_pending=1 and busy=0:
  - bank select toggles;
  - key_valid<=1;
  - active_nr<=10/12/14;
  - swap_pending<=0; counter<=0;
  - load_done_pulse<=1 for exactly one cycle.
  - With busy=0 throughout, load_done_pulse is high in the 2nd cycle after the last-word edge.
  - A new load may start in the cycle after the swap edge.
- Rejected writes: wr_err_irq_pulse fires for one cycle and the word is dropped when:
  - en_wr=1 while swap_pending=1;
  - en_wr=1 as a first word with key_len=3; the counter stays 0.
- Read:
  - rd_key is updated one edge after rd_en=1 and holds when rd_en=0.
  - The read uses the bank select value before the edge, so a read on the swap edge returns the old bank.
  - rd_key=0 if key_valid=0 or rd_addr>active_nr.
- The shadow bank is never readable. The active bank is never written.
- Storage: two arrays of NK_MAX x 2*WORD_W, or an equivalent inferred RAM.

Test Plan:
- Basic load: key_len=0, busy=0, 22 words with value i for i=0..21.
  - load_done_pulse is high one cycle, 2 cycles after the 22nd-word edge; active_nr=10; key_valid=1.
  - rd_addr=3 returns 128'h7_0000000000000006. rd_addr=11 returns 0.
- Busy hold: key A active, load key B (words 0x100+i) with busy=1.
  - swap_pending=1 and reads keep returning A for 20 cycles.
  - On the edge after busy drops: swap, load_done_pulse, reads return B.
- Read on swap edge: rd_en=1 with rd_addr=0 on the swap edge returns A's key 0. The next read returns B's key 0.
- Overflow: a 23rd word sent while pending gives one wr_err_irq_pulse; after the swap, B's contents are unchanged.
- AES-256: key_len=2, 30 words.
  - active_nr=14; rd_addr=14 returns {word29,word28}.
  - A reserved first word (key_len=3) gives an error pulse, and the counter stays 0.
- Reset mid-load: kill after 10 words.
  - All outputs are 0 and key_valid=0.
  - A fresh 22-word load afterwards completes normally.
